// File: rtl/serial_tc_pkg.sv
// Shared types and helpers for the multi-lane serial two's-complement negator.
// Lane FSM encoding, mode encodings and the bit-index width helper live here.
package serial_tc_pkg;

  typedef enum logic {
    SEEK   = 1'b0,
    INVERT = 1'b1
  } lane_state_e;

  localparam logic MODE_PASS = 1'b0;
  localparam logic MODE_NEG  = 1'b1;

  // Width of the bit index counter; never narrower than one bit.
  function automatic int idx_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_tc_lane.sv
// One serial lane: copy-until-first-one then invert, plus most-negative detect.
// Output bit and overflow are registered so the lane adds exactly one cycle.
module serial_tc_lane
  import serial_tc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_accept,
  input  logic i_first,
  input  logic i_last,
  input  logic i_mode,
  input  logic i_bit,
  output logic o_bit,
  output logic o_ovf
);

  lane_state_e r_state;
  lane_state_e w_cur;
  logic        r_bit;
  logic        r_ovf;
  logic        w_seek;
  logic        w_neg;

  // A new word always starts looking for its first one, whatever came before.
  always_comb begin
    w_cur  = i_first ? SEEK : r_state;
    w_seek = (w_cur == SEEK);
    w_neg  = (i_mode == MODE_NEG);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= SEEK;
      r_bit   <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (i_clear) begin
      r_state <= SEEK;
      r_ovf   <= 1'b0;
    end else if (i_accept) begin
      r_bit   <= (w_neg && !w_seek) ? ~i_bit : i_bit;
      r_state <= (w_seek && i_bit) ? INVERT : w_cur;
      // MSB set with no earlier one means 100..0, which has no positive twin.
      r_ovf   <= i_last & w_neg & w_seek & i_bit;
    end else begin
      r_ovf   <= 1'b0;
    end
  end

  assign o_bit = r_bit;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/serial_tc_negator.sv
// CH lockstep LSB-first serial lanes, W-bit words, negate or pass per word.
// Owns the shared bit index, per-word mode latch and the valid/word_last stage.
module serial_tc_negator
  import serial_tc_pkg::*;
#(
  parameter int W  = 8,
  parameter int CH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 abort,
  input  logic                 in_valid,
  input  logic [CH-1:0]        in_bit,
  input  logic                 mode,
  output logic                 out_valid,
  output logic [CH-1:0]        out_bit,
  output logic                 word_last,
  output logic [CH-1:0]        ovf,
  output logic [idx_w(W)-1:0]  bit_idx
);

  localparam int            IW       = idx_w(W);
  localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

  logic [IW-1:0] r_idx;
  logic          r_mode;
  logic          r_out_valid;
  logic          r_word_last;
  logic          w_accept;
  logic          w_first;
  logic          w_last;
  logic          w_mode;

  // Mode is taken live on bit 0 and from the latch for the rest of the word.
  always_comb begin
    w_accept = in_valid & ~abort;
    w_first  = (r_idx == '0);
    w_last   = (r_idx == LAST_IDX);
    w_mode   = w_first ? mode : r_mode;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx       <= '0;
      r_mode      <= MODE_PASS;
      r_out_valid <= 1'b0;
      r_word_last <= 1'b0;
    end else if (abort) begin
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_word_last <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      r_word_last <= in_valid & w_last;
      if (in_valid) begin
        r_idx <= w_last ? '0 : r_idx + 1'b1;
        if (w_first) r_mode <= mode;
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_lane
    serial_tc_lane u_lane (
      .clk      (clk),
      .reset    (reset),
      .i_clear  (abort),
      .i_accept (w_accept),
      .i_first  (w_first),
      .i_last   (w_last),
      .i_mode   (w_mode),
      .i_bit    (in_bit[g]),
      .o_bit    (out_bit[g]),
      .o_ovf    (ovf[g])
    );
  end

  assign out_valid = r_out_valid;
  assign word_last = r_word_last;
  assign bit_idx   = r_idx;

endmodule

// File: tb/tb_serial_tc_negator.sv
// Directed bench for serial_tc_negator (W=8, CH=2) with hand-computed words.
module tb_serial_tc_negator;

  localparam int W  = 8;
  localparam int CH = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic [CH-1:0] in_bit = '0;
  logic          mode = 1'b0;
  logic          out_valid;
  logic [CH-1:0] out_bit;
  logic          word_last;
  logic [CH-1:0] ovf;
  logic [2:0]    bit_idx;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            gap_pat [8];
  logic [7:0]    got_a, got_b;
  logic [1:0]    got_ovf;
  logic [1:0]    prev_bits;

  serial_tc_negator #(.W(W), .CH(CH)) dut (
    .clk       (clk),
    .reset     (reset),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .mode      (mode),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .word_last (word_last),
    .ovf       (ovf),
    .bit_idx   (bit_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Send one word per lane; mode flips to ~m0 from bit index tog (tog<0: never).
  task automatic send_word(input logic [7:0] a, input logic [7:0] b,
                           input logic m0, input int tog);
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < gap_pat[i]; g++) begin
        in_valid = 1'b0;
        in_bit   = 2'($urandom);
        mode     = 1'($urandom);
        @(posedge clk); #1;
        chk("gap_valid", 32'(out_valid), 32'd0);
        chk("gap_hold", 32'(out_bit), 32'(prev_bits));
      end
      in_valid = 1'b1;
      in_bit   = {b[i], a[i]};
      mode     = (tog >= 0 && i >= tog) ? ~m0 : m0;
      @(posedge clk); #1;
      chk("valid", 32'(out_valid), 32'd1);
      chk("word_last", 32'(word_last), (i == 7) ? 32'd1 : 32'd0);
      chk("bit_idx", 32'(bit_idx), 32'((i + 1) % 8));
      got_a[i]  = out_bit[0];
      got_b[i]  = out_bit[1];
      prev_bits = out_bit;
      if (i == 7) got_ovf = ovf;
    end
    in_valid = 1'b0;
  endtask

  task automatic partial(input logic [7:0] a, input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_bit   = {b[i], a[i]};
      mode     = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic word_chk(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                          input logic [1:0] eovf);
    chk({tag, "_lane0"}, 32'(got_a), 32'(ea));
    chk({tag, "_lane1"}, 32'(got_b), 32'(eb));
    chk({tag, "_ovf"}, 32'(got_ovf), 32'(eovf));
  endtask

  initial begin
    foreach (gap_pat[i]) gap_pat[i] = 0;
    prev_bits = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_bits", 32'(out_bit), 32'd0);
    chk("rst_last", 32'(word_last), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_idx", 32'(bit_idx), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Negate basics
    send_word(8'h16, 8'h7F, 1'b1, -1); word_chk("neg16_7f", 8'hEA, 8'h81, 2'b00);
    send_word(8'h80, 8'h00, 1'b1, -1); word_chk("neg80_00", 8'h80, 8'h00, 2'b01);
    send_word(8'h01, 8'hFF, 1'b1, -1); word_chk("neg01_ff", 8'hFF, 8'h01, 2'b00);

    // Back-to-back words, no gap between them
    send_word(8'h16, 8'h7F, 1'b1, -1); word_chk("b2b_w0", 8'hEA, 8'h81, 2'b00);
    send_word(8'h03, 8'h02, 1'b1, -1); word_chk("b2b_w1", 8'hFD, 8'hFE, 2'b00);

    // Mid-word mode change ignored; following word negated
    send_word(8'h16, 8'h80, 1'b0, 3);  word_chk("pass_tog", 8'h16, 8'h80, 2'b00);
    send_word(8'h16, 8'h80, 1'b1, -1); word_chk("after_pass", 8'hEA, 8'h80, 2'b10);

    // Gaps of 1..3 cycles inside the word
    gap_pat = '{0, 2, 0, 1, 3, 0, 1, 2};
    send_word(8'h16, 8'h05, 1'b1, -1); word_chk("gaps", 8'hEA, 8'hFB, 2'b00);
    foreach (gap_pat[i]) gap_pat[i] = 0;

    // Abort at bit_idx 4
    partial(8'h16, 8'h01, 4);
    chk("pre_abort_idx", 32'(bit_idx), 32'd4);
    in_valid = 1'b1; abort = 1'b1; in_bit = 2'b11;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_last", 32'(word_last), 32'd0);
    chk("abort_idx", 32'(bit_idx), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    send_word(8'h05, 8'h80, 1'b1, -1); word_chk("post_abort", 8'hFB, 8'h80, 2'b10);

    // Reset pulsed mid-word instead of abort
    partial(8'h16, 8'h01, 4);
    chk("pre_rst_idx", 32'(bit_idx), 32'd4);
    reset = 1'b0;
    #1;
    chk("mrst_async_valid", 32'(out_valid), 32'd0);
    chk("mrst_async_bits", 32'(out_bit), 32'd0);
    @(posedge clk); #1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_bits", 32'(out_bit), 32'd0);
    chk("mrst_last", 32'(word_last), 32'd0);
    chk("mrst_ovf", 32'(ovf), 32'd0);
    chk("mrst_idx", 32'(bit_idx), 32'd0);
    reset = 1'b1;
    prev_bits = '0;
    send_word(8'h05, 8'h80, 1'b1, -1); word_chk("post_rst", 8'hFB, 8'h80, 2'b10);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
